// File: rtl/lfsr_share_arb_pkg.sv
// Shared definitions for the LFSR sharing arbiter: requester command codes
// and the sequencer state encoding.
package lfsr_share_arb_pkg;

    // Per-requester command codes; 2'b11 is reserved and behaves as a draw.
    localparam logic [1:0] CMD_DRAW   = 2'b00;
    localparam logic [1:0] CMD_MARK   = 2'b01;
    localparam logic [1:0] CMD_REPLAY = 2'b10;
    localparam logic [1:0] CMD_RSVD   = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : lfsr_share_arb_pkg

// File: rtl/lfsr_share_arb_rr_pick.sv
// Round-robin picker: chooses the first set request at or after the pointer,
// wrapping around. Purely combinational; the pointer register lives in the
// caller.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int PW = $clog2(N);

    int cand;

    // Scan from the pointer upward and keep the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr_i) + off) % N;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = PW'(cand);
            end
        end
    end

endmodule : rr_pick

// File: rtl/lfsr_share_arb.sv
// Shares one external LFSR between N requesters. Each grant optionally
// saves or restores the LFSR state, steps it STEPS times, then returns a
// registered slice of the state to the granted requester.
// Optional build macro: LFSR_SHARE_ARB_IDLE_STEP_EN -- when defined the LFSR
// also free-runs in IDLE cycles that carry no request.
module lfsr_share_arb
    import lfsr_share_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 16,
    parameter int STEPS     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req_valid,
    input  logic [2*N-1:0]       req_cmd,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         rsp_valid,
    output logic [OUT_WIDTH-1:0] rsp_data,
    output logic                 lfsr_e,
    output logic                 lfsr_save,
    output logic                 lfsr_restore,
    input  logic [WIDTH-1:0]     lfsr_q
);

    localparam int PW = $clog2(N);
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Reject configurations the datapath cannot support.
    if (STEPS < 1) begin : g_bad_steps
        $error("lfsr_share_arb: STEPS must be at least 1");
    end
    if (N < 2 || N > 8) begin : g_bad_n
        $error("lfsr_share_arb: N must be in 2..8");
    end
    if (OUT_WIDTH > WIDTH) begin : g_bad_out_width
        $error("lfsr_share_arb: OUT_WIDTH must not exceed WIDTH");
    end

    state_e                 state_q, state_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N-1:0]           gnt_q, gnt_d;
    logic [N-1:0]           rsp_valid_q;
    logic [OUT_WIDTH-1:0]   rsp_data_q;

    logic [N-1:0]           pick_grant;
    logic [PW-1:0]          pick_idx;
    logic                   pick_any;
    logic [1:0]             pick_cmd;

    logic [N-1:0]           ready_c;
    logic                   step_c;
    logic                   save_c;
    logic                   restore_c;
    logic                   rsp_fire;

    // Only the low OUT_WIDTH bits of the LFSR state are ever returned.
    logic                   unused_lfsr_bits;
    assign unused_lfsr_bits = &{1'b0, lfsr_q};

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign pick_cmd = req_cmd[{pick_idx, 1'b0} +: 2];

    // Next-state and strobe decode; strobes are combinational from state.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        ready_c   = '0;
        step_c    = 1'b0;
        save_c    = 1'b0;
        restore_c = 1'b0;
        rsp_fire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ready_c   = pick_grant;
                    gnt_d     = pick_grant;
                    ptr_d     = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
                    cnt_d     = CW'(STEPS - 1);
                    // Save captures the pre-draw state; restore lands before the first step.
                    save_c    = (pick_cmd == CMD_MARK);
                    restore_c = (pick_cmd == CMD_REPLAY);
                    state_d   = STEP;
                end
`ifdef LFSR_SHARE_ARB_IDLE_STEP_EN
                else begin
                    step_c = 1'b1;
                end
`endif
            end
            STEP: begin
                step_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rsp_fire = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Response register: one-cycle strobe, data held until the next response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_fire ? gnt_q : '0;
            if (rsp_fire) begin
                rsp_data_q <= lfsr_q[OUT_WIDTH-1:0];
            end
        end
    end

    // Combinational outputs are forced low while reset is held so a pending
    // request cannot produce a grant or strobe during reset.
    assign req_ready    = reset_n ? ready_c : '0;
    assign lfsr_e       = reset_n & step_c;
    assign lfsr_save    = reset_n & save_c;
    assign lfsr_restore = reset_n & restore_c;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

endmodule : lfsr_share_arb

// File: tb/tb_lfsr_share_arb.sv
// Directed bench for lfsr_share_arb: one instance with STEPS=1 and one with
// STEPS=4, each attached to a behavioural LFSR with save/restore.
module tb_lfsr_share_arb;
    import lfsr_share_arb_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        mdl_rst;

    logic [3:0]  req_valid    [2];
    logic [7:0]  req_cmd      [2];
    logic [3:0]  req_ready    [2];
    logic [3:0]  rsp_valid    [2];
    logic [15:0] rsp_data     [2];
    logic        lfsr_e       [2];
    logic        lfsr_save    [2];
    logic        lfsr_restore [2];
    logic [31:0] st           [2];
    logic [31:0] sv           [2];

    int errors = 0;
    int checks = 0;

    lfsr_share_arb #(.N(4), .WIDTH(32), .OUT_WIDTH(16), .STEPS(1)) u_s1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid[0]),
        .req_cmd      (req_cmd[0]),
        .req_ready    (req_ready[0]),
        .rsp_valid    (rsp_valid[0]),
        .rsp_data     (rsp_data[0]),
        .lfsr_e       (lfsr_e[0]),
        .lfsr_save    (lfsr_save[0]),
        .lfsr_restore (lfsr_restore[0]),
        .lfsr_q       (st[0])
    );

    lfsr_share_arb #(.N(4), .WIDTH(32), .OUT_WIDTH(16), .STEPS(4)) u_s4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid[1]),
        .req_cmd      (req_cmd[1]),
        .req_ready    (req_ready[1]),
        .rsp_valid    (rsp_valid[1]),
        .rsp_data     (rsp_data[1]),
        .lfsr_e       (lfsr_e[1]),
        .lfsr_save    (lfsr_save[1]),
        .lfsr_restore (lfsr_restore[1]),
        .lfsr_q       (st[1])
    );

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [31:0] step_n(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = xs(y);
        return y;
    endfunction

    // Behavioural LFSR with save/restore; strobes take effect at the next edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mdl_rst) begin
                st[i] <= 32'h1234_5678 ^ (i * 32'h0101_0101);
                sv[i] <= 32'h0;
            end else begin
                if (lfsr_restore[i])  st[i] <= sv[i];
                else if (lfsr_e[i])   st[i] <= xs(st[i]);
                if (lfsr_save[i])     sv[i] <= st[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_ready"},   32'(req_ready[d]), 0);
        chk({tag, "_rspv"},    32'(rsp_valid[d]), 0);
        chk({tag, "_rspd"},    32'(rsp_data[d]), 0);
        chk({tag, "_strobes"}, {29'd0, lfsr_e[d], lfsr_save[d], lfsr_restore[d]}, 0);
    endtask

    // One complete draw on instance d by requester id.
    task automatic draw(input int d, input int id, input logic [1:0] cmd, input int steps,
                        input bit chk_val, output logic [15:0] val);
        logic [31:0] pre;
        logic [31:0] q;
        logic [3:0]  oh;
        oh = 4'b0001 << id;
        nxt();
        req_valid[d] = oh;
        req_cmd[d]   = 8'(cmd) << (2 * id);
        #1;
        pre = st[d];
        chk("grant_ready",   32'(req_ready[d]), 32'(oh));
        chk("grant_e",       32'(lfsr_e[d]), 0);
        chk("grant_save",    32'(lfsr_save[d]), 32'(cmd == CMD_MARK));
        chk("grant_restore", 32'(lfsr_restore[d]), 32'(cmd == CMD_REPLAY));
        for (int s = 0; s < steps; s++) begin
            nxt();
            req_valid[d] = '0;
            req_cmd[d]   = '0;
            #1;
            chk("step_e",       32'(lfsr_e[d]), 1);
            chk("step_ready",   32'(req_ready[d]), 0);
            chk("step_strobes", {30'd0, lfsr_save[d], lfsr_restore[d]}, 0);
            chk("step_rspv",    32'(rsp_valid[d]), 0);
        end
        nxt();
        #1;
        chk("resp_e",    32'(lfsr_e[d]), 0);
        chk("resp_rspv", 32'(rsp_valid[d]), 0);
        q = st[d];
        if (chk_val) chk("resp_state", q, step_n(pre, steps));
        nxt();
        #1;
        chk("rsp_valid", 32'(rsp_valid[d]), 32'(oh));
        chk("rsp_data",  32'(rsp_data[d]), 32'(q[15:0]));
        val = rsp_data[d];
        $display("draw dut=%0d req=%0d cmd=%0d steps=%0d data=%04h", d, id, cmd, steps, val);
    endtask

    logic [15:0] v, a, x, r;

    initial begin
        reset_n      = 1'b0;
        mdl_rst      = 1'b1;
        req_valid[0] = 4'hF;
        req_valid[1] = 4'hF;
        req_cmd[0]   = '0;
        req_cmd[1]   = '0;

        // Reset held with all requests pending: everything quiet.
        for (int c = 0; c < 3; c++) begin
            nxt();
            #1;
            chk_zero(0, "rst_s1");
            chk_zero(1, "rst_s4");
        end
        $display("reset hold: outputs checked with req_valid=1111");

        // Release; contention on the STEPS=1 instance.
        nxt();
        req_valid[1] = '0;
        mdl_rst      = 1'b0;
        reset_n      = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                nxt();
                #1;
            end
            chk("cont_ready", 32'(req_ready[0]), 32'(4'b0001 << (k % 4)));
            chk("cont_rspv",  32'(rsp_valid[0]), (k == 0) ? 0 : 32'(4'b0001 << ((k - 1) % 4)));
            $display("contention grant %0d: req_ready=%b", k, req_ready[0]);
            for (int g = 0; g < 2; g++) begin
                nxt();
                #1;
                chk("cont_gap", 32'(req_ready[0]), 0);
            end
        end
        nxt();
        req_valid[0] = '0;
        #1;
        chk("cont_last_rspv",  32'(rsp_valid[0]), 32'(4'b0001));
        chk("cont_last_ready", 32'(req_ready[0]), 0);

        // Single draw, then mark / intervening draws / replay.
        draw(0, 0, CMD_DRAW, 1, 1'b1, v);
        draw(0, 1, CMD_MARK, 1, 1'b1, a);
        for (int i = 0; i < 3; i++) begin
            draw(0, 2, CMD_DRAW, 1, 1'b1, x);
            chk("replay_distinct", 32'(x != a), 1);
        end
        draw(0, 3, CMD_REPLAY, 1, 1'b0, r);
        chk("replay_match", 32'(r), 32'(a));

        // STEPS=4 instance: four step cycles, response at T+6.
        draw(1, 0, CMD_DRAW, 4, 1'b1, v);

        // Reset pulse in the middle of a STEPS=4 draw.
        nxt();
        req_valid[1] = 4'b0100;
        #1;
        chk("mid_grant", 32'(req_ready[1]), 32'(4'b0100));
        nxt();
        req_valid[1] = '0;
        #1;
        chk("mid_step_e", 32'(lfsr_e[1]), 1);
        nxt();
        reset_n = 1'b0;
        #1;
        chk_zero(1, "mid_rst");
        nxt();
        reset_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) nxt();
            #1;
            chk("post_rst_rspv", 32'(rsp_valid[1]), 0);
            chk("post_rst_e",    32'(lfsr_e[1]), 0);
        end
        $display("mid-draw reset: no stale response");

        // Pointer back at 0: with all requesting, requester 0 wins.
        nxt();
        req_valid[1] = 4'hF;
        #1;
        chk("ptr_reset_grant", 32'(req_ready[1]), 32'(4'b0001));
        for (int c = 0; c < 5; c++) begin
            nxt();
            req_valid[1] = '0;
            #1;
        end
        nxt();
        #1;
        chk("ptr_reset_rspv", 32'(rsp_valid[1]), 32'(4'b0001));
        $display("post-reset grant to requester 0, data=%04h", rsp_data[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lfsr_share_arb

// File: doc/lfsr_share_arb.md
Name: lfsr_share_arb

Overview:
- Sequencer/arbiter that shares one external LFSR instance between N requesters.
- Round-robin grants; for each grant it steps the LFSR a fixed number of times and returns a registered slice of its state.
- Drives the LFSR's save/restore strobes so a requester can mark a point in the sequence and another requester can replay it.
- Sits between noise/dither consumers (audio, video, test pattern blocks) and a single LFSR.

Parameters:
- N, 4: number of requesters (2..8).
- WIDTH, 32: width of the attached LFSR state.
- OUT_WIDTH, 16: bits returned per draw, taken as lfsr_q[OUT_WIDTH-1:0]. OUT_WIDTH <= WIDTH.
- STEPS, 1: LFSR advances per draw. STEPS >= 1; 0 is an elaboration error.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- req_valid, in, N: per-requester draw request.
- req_cmd, in, 2*N: per-requester command, requester i in bits [2i+1:2i]. 00 DRAW, 01 MARK, 10 REPLAY, 11 reserved (treated as DRAW).
- req_ready, out, N: one-hot grant, one cycle wide.
- rsp_valid, out, N: one-hot response strobe, one cycle wide.
- rsp_data, out, OUT_WIDTH: response word, shared by all requesters.
- lfsr_e, out, 1: LFSR step enable.
- lfsr_save, out, 1: LFSR save strobe.
- lfsr_restore, out, 1: LFSR restore strobe.
- lfsr_q, in, WIDTH: LFSR state. Registered in the LFSR; a strobe in cycle t is visible at t+1.

Behaviour:
- Reset (async, reset_n low): state=IDLE, rr pointer=0, step count=0, all outputs 0 (req_ready, rsp_valid, rsp_data, lfsr_* strobes). Reset mid-operation aborts the draw silently; no rsp_valid is issued afterwards.
- States: IDLE, STEP, RESP.
- IDLE, when any req_valid is set (grant cycle T):
  - Pick the first valid requester at or after the rr pointer (wrapping); call it g.
  - Assert req_ready[g]. Latch g and its cmd. Set rr pointer = (g+1) mod N. Load count = STEPS-1. Go to STEP.
  - MARK: lfsr_save=1 in cycle T, so the state saved is the pre-draw state.
  - REPLAY: lfsr_restore=1 in cycle T; the restored state is present at T+1, before the first step.
  - DRAW: no save/restore.
- STEP: lfsr_e=1 every cycle. While count != 0, decrement. At count == 0, go to RESP. lfsr_e is high exactly STEPS consecutive cycles (T+1..T+STEPS).
- RESP (cycle T+STEPS+1): on the exiting edge, rsp_data <= lfsr_q[OUT_WIDTH-1:0] and rsp_valid <= onehot(g). Go to IDLE.
- rsp_valid is high for one cycle at T+STEPS+2. rsp_data holds its value until the next response.
- No backpressure on responses.
- A new grant may coincide with the cycle rsp_valid is high. Throughput: one draw per STEPS+2 cycles.
- lfsr_e, lfsr_save and lfsr_restore are never asserted in the same cycle. save and restore are mutually exclusive by construction.
- Requesters hold req_valid and req_cmd until req_ready. req_valid is sampled only in IDLE; a request dropped before grant is simply ignored.
- Replay guarantee: a REPLAY draw after a MARK returns the same rsp_data as the MARK draw, regardless of intervening draws. REPLAY with no prior MARK restores whatever the LFSR holds in its save register (undefined after power-up).

Optional Feature:
- Macro LFSR_SHARE_ARB_IDLE_STEP_EN.
- Defined: lfsr_e=1 in every IDLE cycle where no req_valid is set (free-running whitening between draws). The replay guarantee still holds, because restore precedes the STEPS draw steps.
- Undefined: lfsr_e is asserted only in STEP.

Decomposition:
- Package lfsr_share_arb_pkg holds:
  - cmd encodings: CMD_DRAW=2'b00, CMD_MARK=2'b01, CMD_REPLAY=2'b10.
  - state encodings: IDLE, STEP, RESP.
- Sub-module rr_pick #(N): inputs req[N] and pointer. Outputs a one-hot grant and a binary index, purely combinational. The pointer register stays in lfsr_share_arb.

Test Plan:
- Reset: hold reset_n low with req_valid=4'b1111 -> all outputs 0, no lfsr_e. After release, the first grant goes to requester 0.
- Single DRAW, STEPS=1, req_valid=0001 at T -> req_ready=0001 at T, lfsr_e at T+1 only, rsp_valid=0001 at T+3. rsp_data equals lfsr_q[15:0] as observed at T+2.
- Contention, req_valid=1111 held -> grants 0,1,2,3,0 spaced 3 cycles apart, rsp_valid order matching.
- Replay: req1 MARK -> value A; req2 DRAW x3 -> three values != A; req3 REPLAY -> rsp_data == A. lfsr_save seen only on the MARK grant, lfsr_restore only on the REPLAY grant.
- STEPS=4 -> lfsr_e high exactly 4 consecutive cycles per draw, rsp_valid at T+6.
- reset_n pulsed low during STEP -> all outputs 0 immediately, no stale rsp_valid after release, rr pointer back to 0.
